// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO holding {pc, inst} pairs, with single-cycle branch flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when the queue is empty.
module fetch_queue #(
  parameter int WIDTH  = 64,
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [IWIDTH-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_pc,
  output logic [IWIDTH-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0]  pcMem   [DEPTH];
  logic [IWIDTH-1:0] instMem [DEPTH];

  logic empty;
  logic full;
  logic bypass;
  logic doEnq;
  logic doDeq;

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);

  assign in_ready = !full && !flush && !rst;
  assign count    = wrPtr_q - rdPtr_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = !empty && !flush && !rst;
    out_pc    = '0;
    out_inst  = '0;
    if (out_valid) begin
      out_pc   = pcMem[rdPtr_q[AW-1:0]];
      out_inst = instMem[rdPtr_q[AW-1:0]];
    end
    if (bypass) begin
      out_valid = in_valid;
      if (in_valid) begin
        out_pc   = in_pc;
        out_inst = in_inst;
      end
    end
  end

  // A bypassed instruction that decode takes immediately is never written.
  assign doEnq = in_valid && in_ready && !(bypass && out_ready);
  assign doDeq = out_valid && out_ready && !empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doEnq) wrPtr_d = wrPtr_q + PW'(1);
    if (doDeq) rdPtr_d = rdPtr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (doEnq) begin
      pcMem[wrPtr_q[AW-1:0]]   <= in_pc;
      instMem[wrPtr_q[AW-1:0]] <= in_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue; expectations adapt when FETCH_QUEUE_BYPASS_EN is defined.
module tb_fetch_queue;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int     testsRun;
  int     testsFailed;
  entry_t sbQ[$];
  entry_t exp;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fetch_queue #(.WIDTH(64), .IWIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [63:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = instOf(pc);
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 64'h0 || out_inst !== 32'h0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got count=%0d ov=%b pc=%h inst=%h ir=%b expected 0 0 0 0 1",
               count, out_valid, out_pc, out_inst, in_ready);
    end
    sbQ.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
      @(negedge clk);
      testsRun++;
      if (in_ready !== 1'b1) begin
        testsFailed++; $display("[TB] FAIL fill_ready_%0d: got %b expected 1", i, in_ready);
      end
      if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 64'h8000_0010, 1'b0, 1'b0);
      @(negedge clk);
      testsRun++;
      if (in_ready !== 1'b0 || count !== 3'd4 || out_valid !== 1'b1 || out_pc !== 64'h8000_0000) begin
        testsFailed++;
        $display("[TB] FAIL full_hold_%0d: got ir=%b count=%0d ov=%b pc=%h expected 0 4 1 80000000",
                 k, in_ready, count, out_valid, out_pc);
      end
      if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(k == 0, 64'h8000_0010, 1'b1, 1'b0);
      @(negedge clk);
      testsRun++;
      if (count !== 3'(4 - k) || in_ready !== (k != 0)) begin
        testsFailed++;
        $display("[TB] FAIL drain_count_%0d: got count=%0d ir=%b expected %0d %b", k, count, in_ready, 4 - k, k != 0);
      end
      if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
      if (out_valid && out_ready) begin
        testsRun++;
        if (sbQ.size() == 0) begin
          testsFailed++; $display("[TB] FAIL drain_spurious: got pc %h expected no output", out_pc);
        end else begin
          exp = sbQ.pop_front();
          if (out_pc !== exp.pc || out_inst !== exp.inst) begin
            testsFailed++;
            $display("[TB] FAIL drain_order: got %h/%h expected %h/%h", out_pc, out_inst, exp.pc, exp.inst);
          end
        end
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    testsRun++;
    if (count !== 3'd0 || out_valid !== 1'b0 || sbQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain_empty: got count=%0d ov=%b pending=%0d expected 0 0 0", count, out_valid, sbQ.size());
    end
  endtask

  task automatic test_stream();
    logic [2:0] expCount;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      drive(k < 20, 64'h8000_0020 + 64'(4 * k), 1'b1, 1'b0);
      @(negedge clk);
      expCount = (BYPASS || k == 0) ? 3'd0 : 3'd1;
      testsRun++;
      if (count !== expCount) begin
        testsFailed++; $display("[TB] FAIL stream_count_%0d: got %0d expected %0d", k, count, expCount);
      end
      if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
      if (out_valid && out_ready) begin
        testsRun++;
        if (sbQ.size() == 0) begin
          testsFailed++; $display("[TB] FAIL stream_spurious: got pc %h expected no output", out_pc);
        end else begin
          exp = sbQ.pop_front();
          if (out_pc !== exp.pc || out_inst !== exp.inst) begin
            testsFailed++;
            $display("[TB] FAIL stream_order: got %h/%h expected %h/%h", out_pc, out_inst, exp.pc, exp.inst);
          end
        end
      end else if (k > 0 && k < 20) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL stream_bubble_%0d: got out_valid=%b expected 1", k, out_valid);
      end
    end
    testsRun++;
    if (sbQ.size() != 0) begin
      testsFailed++; $display("[TB] FAIL stream_lost: got %0d undelivered expected 0", sbQ.size());
    end
    sbQ.delete();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 64'h8000_0040 + 64'(4 * i), 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
    end
    @(posedge clk); #1;
    drive(1'b1, 64'h8000_0050, 1'b1, 1'b1);
    @(negedge clk);
    testsRun++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 3'd3) begin
      testsFailed++;
      $display("[TB] FAIL flush_cycle: got ir=%b ov=%b count=%0d expected 0 0 3", in_ready, out_valid, count);
    end
    sbQ.delete();
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    testsRun++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL flush_after: got count=%0d ov=%b expected 0 0", count, out_valid);
    end
    @(posedge clk); #1;
    drive(1'b1, 64'h8000_0100, 1'b0, 1'b0);
    @(negedge clk);
    if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    testsRun++;
    if (out_valid !== 1'b1 || sbQ.size() == 0) begin
      testsFailed++; $display("[TB] FAIL flush_refill: got ov=%b pending=%0d expected 1 1", out_valid, sbQ.size());
    end else begin
      exp = sbQ.pop_front();
      if (out_pc !== exp.pc || out_inst !== exp.inst) begin
        testsFailed++;
        $display("[TB] FAIL flush_refill_head: got %h/%h expected %h/%h", out_pc, out_inst, exp.pc, exp.inst);
      end
    end
  endtask

  task automatic test_rst_mid();
    bit delivered;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 64'h8000_0200 + 64'(4 * i), 1'b0, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rst_mid_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sbQ.delete();
    @(negedge clk);
    testsRun++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 64'h0 || in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_state: got ov=%b count=%0d pc=%h ir=%b expected 0 0 0 1",
               out_valid, count, out_pc, in_ready);
    end
    delivered = 1'b0;
    for (int k = 0; k < 4 && !delivered; k++) begin
      @(posedge clk); #1;
      drive(k == 0, 64'h8000_0000, 1'b1, 1'b0);
      @(negedge clk);
      if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
      if (out_valid && out_ready && sbQ.size() != 0) begin
        exp = sbQ.pop_front();
        delivered = 1'b1;
        testsRun++;
        if (out_pc !== exp.pc || out_inst !== exp.inst) begin
          testsFailed++;
          $display("[TB] FAIL rst_mid_first: got %h/%h expected %h/%h", out_pc, out_inst, exp.pc, exp.inst);
        end
      end
    end
    if (!delivered) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL rst_mid_timeout: got no output expected pc 80000000");
    end
  endtask

  task automatic test_bypass_empty();
    @(posedge clk); #1;
    drive(1'b1, 64'h8000_0010, 1'b1, 1'b0);
    @(negedge clk);
    if (in_valid && in_ready) sbQ.push_back('{pc: in_pc, inst: in_inst});
    testsRun++;
    if (out_valid !== BYPASS || count !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL empty_offer: got ov=%b count=%0d expected %b 0", out_valid, count, BYPASS);
    end
    if (BYPASS && out_valid && out_ready) begin
      exp = sbQ.pop_front();
      testsRun++;
      if (out_pc !== exp.pc || out_inst !== exp.inst) begin
        testsFailed++;
        $display("[TB] FAIL bypass_data: got %h/%h expected %h/%h", out_pc, out_inst, exp.pc, exp.inst);
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    testsRun++;
    if (count !== (BYPASS ? 3'd0 : 3'd1)) begin
      testsFailed++; $display("[TB] FAIL empty_offer_count: got %0d expected %0d", count, BYPASS ? 0 : 1);
    end
    if (out_valid && out_ready) begin
      testsRun++;
      if (sbQ.size() == 0) begin
        testsFailed++; $display("[TB] FAIL empty_offer_spurious: got pc %h expected no output", out_pc);
      end else begin
        exp = sbQ.pop_front();
        if (out_pc !== exp.pc || out_inst !== exp.inst) begin
          testsFailed++;
          $display("[TB] FAIL delayed_data: got %h/%h expected %h/%h", out_pc, out_inst, exp.pc, exp.inst);
        end
      end
    end
    testsRun++;
    if (sbQ.size() != 0) begin
      testsFailed++; $display("[TB] FAIL empty_offer_lost: got %0d undelivered expected 0", sbQ.size());
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_rst_mid();
    test_bypass_empty();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
